secuenciador_restador: RTL and testbench
========================================

// Module: secuenciador_restador
//
// PURPOSE
// Upstream/downstream control stage wrapped around restador_circular.
// - Captures operands A and B serially from one shared input bus using a load strobe.
// - Drives them to the combinational subtractor and waits a settle time.
// - Registers Y and the Z/N/C/V flags, then holds them under a valid/ack handshake.
// - Keeps a saturating count of overflow (V=1) results.
//
// PARAMETERS
// WIDTH    4  operand/result width; must match restador_circular.
// SETTLE   1  cycles between operand-B capture and result latch; legal range >=1.
// CNT_W    8  width of the overflow counter.
//
// PORTS
// clk        in   1      system clock; all logic on the rising edge.
// rst_n      in   1      asynchronous active-low reset.
// borrar     in   1      synchronous clear: abort any operation, return to ESPERA_A.
// dato_in    in   WIDTH  operand bus, sampled when cargar=1.
// cargar     in   1      single-cycle load strobe.
// op_a       out  WIDTH  registered operand A, to subtractor A.
// op_b       out  WIDTH  registered operand B, to subtractor B.
// y_in       in   WIDTH  subtractor Y.
// z_in       in   1      subtractor Z flag.
// n_in       in   1      subtractor N flag.
// c_in       in   1      subtractor C flag.
// v_in       in   1      subtractor V flag.
// res_y      out  WIDTH  latched result.
// res_flags  out  4      latched flags, ordered {Z,N,C,V}.
// res_valid  out  1      result available; held until acknowledged.
// res_ack    in   1      consumer acknowledge.
// ocupado    out  1      high in CALCULA and RESULTADO.
// cnt_ovf    out  CNT_W  saturating count of latched results with V=1.
//
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous):
//   - op_a, op_b, res_y, res_flags, cnt_ovf = 0.
//   - res_valid = 0, ocupado = 0, state = ESPERA_A.
// - FSM states: ESPERA_A -> ESPERA_B -> CALCULA -> RESULTADO -> ESPERA_A.
// - ESPERA_A: cargar=1 loads op_a <= dato_in, then goes to ESPERA_B.
// - ESPERA_B: cargar=1 loads op_b <= dato_in, clears the settle counter, then goes to CALCULA.
// - CALCULA:
//   - Settle counter counts SETTLE cycles.
//   - On the last cycle: res_y <= y_in, res_flags <= {z_in,n_in,c_in,v_in}, res_valid <= 1.
//   - Goes to RESULTADO.
//   - cnt_ovf += 1 if v_in=1, saturating at all-ones; no wrap.
// - Latency: res_valid rises SETTLE+1 cycles after the edge that samples cargar for operand B.
// - RESULTADO:
//   - res_y and res_flags are stable and res_valid=1 until a cycle with res_ack=1.
//   - That cycle: res_valid <= 0, return to ESPERA_A.
// - cargar in CALCULA/RESULTADO is ignored; it is not queued, even if it coincides with res_ack.
// - res_ack outside RESULTADO is ignored.
// - op_a/op_b keep their values after the result is consumed, until overwritten by the next load.
// - borrar=1 in any state:
//   - State goes to ESPERA_A and res_valid goes to 0.
//   - op_a, op_b and cnt_ovf are unchanged.
//   - borrar takes priority over cargar and res_ack in the same cycle.
// - rst_n asserted mid-operation aborts immediately. After release, the block waits in ESPERA_A.
// - The block does no arithmetic on data. Flag semantics are exactly those of restador_circular.
//
// TESTING
// Bench instantiates this block connected to restador_circular, WIDTH=4, SETTLE=1.
// - Load 5 then 3 -> res_valid 2 cycles after the B load.
//   res_y=0010, Z=0, N=0, V=0; held until res_ack.
// - Load 7 then 7 -> res_y=0000, Z=1, N=0, V=0.
//   Assert res_ack one cycle later -> res_valid=0, state ESPERA_A.
// - Load 7 then 15 -> res_y=1000, N=1, V=1, cnt_ovf increments by 1.
//   Repeat 300 times with CNT_W=8 -> cnt_ovf saturates at 255.
// - Load 3 then 5 -> res_y=1110, N=1.
//   Pulse cargar with dato_in=9 during RESULTADO and CALCULA -> ignored, op_a stays 3.
// - Load A=8, then assert borrar in ESPERA_B -> returns to ESPERA_A, no res_valid.
//   Drop rst_n during CALCULA -> all outputs 0 immediately.
// - Hold res_ack=1 continuously, then run 0 - 1 -> res_y=1111, res_valid pulses exactly 1 cycle.

Source files
------------

// File: rtl/secuenciador_restador.sv
// Control stage around restador_circular: serial operand capture, settle wait,
// result latch with valid/ack handshake and a saturating overflow counter.
module secuenciador_restador #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             borrar,
  input  logic [WIDTH-1:0] dato_in,
  input  logic             cargar,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] y_in,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] res_y,
  output logic [3:0]       res_flags,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             ocupado,
  output logic [CNT_W-1:0] cnt_ovf
);

  typedef enum logic [1:0] {
    ESPERA_A  = 2'd0,
    ESPERA_B  = 2'd1,
    CALCULA   = 2'd2,
    RESULTADO = 2'd3
  } estado_t;

  // The counter runs 0..SETTLE: SETTLE settle cycles plus the latch cycle.
  localparam int SET_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  estado_t          estado_q,    estado_d;
  logic [SET_W-1:0] cuenta_q,    cuenta_d;
  logic [WIDTH-1:0] op_a_q,      op_a_d;
  logic [WIDTH-1:0] op_b_q,      op_b_d;
  logic [WIDTH-1:0] res_y_q,     res_y_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic             res_valid_q, res_valid_d;
  logic             ocupado_q,   ocupado_d;
  logic [CNT_W-1:0] cnt_ovf_q,   cnt_ovf_d;

  // Next-state and datapath update; borrar overrides every other request.
  always_comb begin
    estado_d    = estado_q;
    cuenta_d    = cuenta_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_y_d     = res_y_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    cnt_ovf_d   = cnt_ovf_q;

    if (borrar) begin
      estado_d    = ESPERA_A;
      res_valid_d = 1'b0;
    end else begin
      case (estado_q)
        ESPERA_A: begin
          if (cargar) begin
            op_a_d   = dato_in;
            estado_d = ESPERA_B;
          end else begin
            estado_d = ESPERA_A;
          end
        end
        ESPERA_B: begin
          if (cargar) begin
            op_b_d   = dato_in;
            cuenta_d = {SET_W{1'b0}};
            estado_d = CALCULA;
          end else begin
            estado_d = ESPERA_B;
          end
        end
        CALCULA: begin
          if (cuenta_q == SET_LAST) begin
            res_y_d     = y_in;
            res_flags_d = {z_in, n_in, c_in, v_in};
            res_valid_d = 1'b1;
            estado_d    = RESULTADO;
            if (v_in && (cnt_ovf_q != CNT_MAX)) begin
              cnt_ovf_d = cnt_ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              cnt_ovf_d = cnt_ovf_q;
            end
          end else begin
            cuenta_d = cuenta_q + {{(SET_W-1){1'b0}}, 1'b1};
          end
        end
        RESULTADO: begin
          if (res_ack) begin
            res_valid_d = 1'b0;
            estado_d    = ESPERA_A;
          end else begin
            res_valid_d = 1'b1;
          end
        end
        default: begin
          estado_d    = ESPERA_A;
          res_valid_d = 1'b0;
        end
      endcase
    end

    ocupado_d = (estado_d == CALCULA) || (estado_d == RESULTADO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= ESPERA_A;
      cuenta_q    <= {SET_W{1'b0}};
      op_a_q      <= {WIDTH{1'b0}};
      op_b_q      <= {WIDTH{1'b0}};
      res_y_q     <= {WIDTH{1'b0}};
      res_flags_q <= 4'b0000;
      res_valid_q <= 1'b0;
      ocupado_q   <= 1'b0;
      cnt_ovf_q   <= {CNT_W{1'b0}};
    end else begin
      estado_q    <= estado_d;
      cuenta_q    <= cuenta_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_y_q     <= res_y_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
      ocupado_q   <= ocupado_d;
      cnt_ovf_q   <= cnt_ovf_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign res_y     = res_y_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;
  assign ocupado   = ocupado_q;
  assign cnt_ovf   = cnt_ovf_q;

endmodule

// File: tb/tb_secuenciador_restador.sv
// Directed bench for secuenciador_restador with a behavioural 4-bit subtractor
// and a scoreboard of expected results.
module tb_secuenciador_restador;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, borrar, cargar, res_ack;
  logic [W-1:0] dato_in, op_a, op_b, y_in, res_y;
  logic         z_in, n_in, c_in, v_in;
  logic [3:0]   res_flags;
  logic         res_valid, ocupado;
  logic [7:0]   cnt_ovf;

  always #5 clk = ~clk;

  // Subtractor environment: A + ~B + 1, C is carry out (1 = no borrow).
  logic [W:0] suma_s;
  assign suma_s = {1'b0, op_a} + {1'b0, ~op_b} + 5'd1;
  assign y_in   = suma_s[W-1:0];
  assign z_in   = (y_in == 4'd0);
  assign n_in   = y_in[W-1];
  assign c_in   = suma_s[W];
  assign v_in   = (op_a[W-1] ^ op_b[W-1]) & (y_in[W-1] ^ op_a[W-1]);

  secuenciador_restador #(.WIDTH(W), .SETTLE(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .borrar(borrar), .dato_in(dato_in), .cargar(cargar),
    .op_a(op_a), .op_b(op_b), .y_in(y_in), .z_in(z_in), .n_in(n_in), .c_in(c_in),
    .v_in(v_in), .res_y(res_y), .res_flags(res_flags), .res_valid(res_valid),
    .res_ack(res_ack), .ocupado(ocupado), .cnt_ovf(cnt_ovf)
  );

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] f;
  } res_t;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] v);
    @(negedge clk);
    dato_in = v;
    cargar  = 1'b1;
    @(negedge clk);
    cargar  = 1'b0;
  endtask

  // Expected result from signed/unsigned reasoning on the loaded operands.
  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] d;
    res_t       e;
    logic       v;
    d   = {1'b0, a} - {1'b0, b};
    v   = (a[3] != b[3]) && (d[3] != a[3]);
    e.y = d[3:0];
    e.f = {(d[3:0] == 4'd0), d[3], ~d[4], v};
    sb_q.push_back(e);
    if (v && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic wait_res(input string tag, input int exp_lat);
    int   cyc;
    res_t e;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, exp_lat);
    if (res_valid === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " res_y"}, res_y, e.y);
      chk({tag, " flags"}, res_flags, e.f);
      chk({tag, " ocupado"}, ocupado, 1);
    end else begin
      chk({tag, " result present"}, res_valid, 1);
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    chk({tag, " valid after ack"}, res_valid, 0);
    chk({tag, " ocupado after ack"}, ocupado, 0);
  endtask

  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b);
    load(a);
    load(b);
    push_exp(a, b);
    wait_res(tag, 2);
    ack(tag);
  endtask

  initial begin
    rst_n = 1'b0; borrar = 1'b0; cargar = 1'b0; res_ack = 1'b0; dato_in = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst op_a", op_a, 0);
    chk("rst res_flags", res_flags, 0);
    chk("rst valid", res_valid, 0);
    chk("rst ocupado", ocupado, 0);
    chk("rst cnt", cnt_ovf, 0);
    rst_n = 1'b1;

    // 5 - 3, held until acknowledged
    load(4'd5);
    load(4'd3);
    push_exp(4'd5, 4'd3);
    chk("5-3 const flags", sb_q[0].f, 4'b0010);
    wait_res("5-3", 2);
    repeat (3) @(negedge clk);
    chk("5-3 held valid", res_valid, 1);
    chk("5-3 held y", res_y, 4'b0010);
    ack("5-3");

    do_op("7-7", 4'd7, 4'd7);

    // 7 - 15 overflows, then saturation of the counter
    load(4'd7);
    load(4'd15);
    push_exp(4'd7, 4'd15);
    wait_res("7-15", 2);
    chk("7-15 y const", res_y, 4'b1000);
    chk("7-15 cnt", cnt_ovf, 1);
    ack("7-15");
    for (int i = 0; i < 300; i++) do_op("ovf loop", 4'd7, 4'd15);
    chk("cnt saturated model", cnt_ovf, exp_cnt);
    chk("cnt saturated 255", cnt_ovf, 255);

    // 3 - 5 with stray loads in CALCULA and RESULTADO
    load(4'd3);
    load(4'd5);
    push_exp(4'd3, 4'd5);
    dato_in = 4'd9;
    cargar  = 1'b1;
    @(negedge clk);
    cargar  = 1'b0;
    wait_res("3-5", 1);
    chk("3-5 y const", res_y, 4'b1110);
    @(negedge clk);
    cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
    chk("3-5 still valid", res_valid, 1);
    chk("3-5 op_a kept", op_a, 3);
    chk("3-5 op_b kept", op_b, 5);
    @(negedge clk);
    res_ack = 1'b1;
    cargar  = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    cargar  = 1'b0;
    chk("3-5 valid after ack", res_valid, 0);
    @(negedge clk);
    chk("3-5 load not queued", op_a, 3);

    // borrar in ESPERA_B beats a simultaneous load
    load(4'd8);
    chk("borrar pre op_a", op_a, 8);
    @(negedge clk);
    borrar  = 1'b1;
    cargar  = 1'b1;
    dato_in = 4'd4;
    @(negedge clk);
    borrar = 1'b0;
    cargar = 1'b0;
    chk("borrar op_b kept", op_b, 5);
    chk("borrar valid", res_valid, 0);
    chk("borrar ocupado", ocupado, 0);
    chk("borrar cnt kept", cnt_ovf, 255);
    load(4'd1);
    chk("after borrar loads A", op_a, 1);
    chk("after borrar op_b", op_b, 5);

    // asynchronous reset during CALCULA
    load(4'd2);
    chk("calcula ocupado", ocupado, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async op_a", op_a, 0);
    chk("async op_b", op_b, 0);
    chk("async res_y", res_y, 0);
    chk("async cnt", cnt_ovf, 0);
    chk("async ocupado", ocupado, 0);
    chk("async valid", res_valid, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post reset idle", res_valid, 0);

    // res_ack held high: 0 - 1, single-cycle valid pulse
    res_ack = 1'b1;
    load(4'd0);
    load(4'd1);
    push_exp(4'd0, 4'd1);
    wait_res("0-1", 2);
    chk("0-1 y const", res_y, 4'b1111);
    @(negedge clk);
    chk("0-1 pulse end", res_valid, 0);
    @(negedge clk);
    chk("0-1 stays low", res_valid, 0);
    res_ack = 1'b0;

    chk("scoreboard drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
